// File: rtl/nibble_fetch_pkg.sv
// nibble_fetch_pkg: shared FSM state encodings and default sizing for the nibble fetch stage.
package nibble_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_LOAD = 2'd1,
        FETCH_RUN  = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AW    = 4;

endpackage

// File: rtl/nibble_ram.sv
// nibble_ram: DEPTH x 4 program store, synchronous write, combinational read, no reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - nibble written at waddr
//   raddr - read address
//   rdata - nibble stored at raddr (combinational)
module nibble_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_fetch.sv
// nibble_fetch: program buffer and instruction fetch stage feeding the op decoder.
//   clk, rst  - clock, synchronous active-high reset
//   load      - enter load mode (priority over run)
//   run       - enter / stay in run mode
//   din       - nibble to store while loading
//   din_valid - din is written this cycle (LOAD only)
//   move_next - decoder consumed op; advance
//   op        - current instruction nibble
//   op_valid  - op is meaningful
//   pc        - index of the nibble on op
//   count     - number of nibbles loaded
//   full      - count == DEPTH
//   halted    - end of program reached
// Build option: NIBBLE_FETCH_LOOP_EN makes the program wrap to index 0
// instead of halting after the last nibble.
module nibble_fetch
    import nibble_fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          run,
    input  logic [3:0]    din,
    input  logic          din_valid,
    input  logic          move_next,
    output logic [3:0]    op,
    output logic          op_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          full,
    output logic          halted
);

    fetch_state_t  state, state_nxt;
    logic [AW-1:0] wp, wp_nxt, pc_nxt, raddr;
    logic [AW:0]   count_nxt;
    logic [3:0]    op_nxt, rdata;
    logic          op_valid_nxt, halted_nxt, we, last;

    assign we   = (state == FETCH_LOAD) && din_valid && !full;
    // pc sits on the final loaded nibble
    assign last = ({1'b0, pc} + (AW+1)'(1)) >= count;

    nibble_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt    = state;
        wp_nxt       = wp;
        count_nxt    = count;
        pc_nxt       = pc;
        op_nxt       = op;
        op_valid_nxt = op_valid;
        halted_nxt   = halted;
        raddr        = pc + AW'(1);
        case (state)
            FETCH_IDLE:
                if (load) begin
                    state_nxt = FETCH_LOAD;
                    wp_nxt    = '0;
                    count_nxt = '0;
                end else if (run && count != '0) begin
                    state_nxt    = FETCH_RUN;
                    pc_nxt       = '0;
                    raddr        = '0;
                    op_nxt       = rdata;
                    op_valid_nxt = 1'b1;
                end
            FETCH_LOAD: begin
                if (we) begin
                    wp_nxt    = wp + AW'(1);
                    count_nxt = count + (AW+1)'(1);
                end
                if (!load) state_nxt = FETCH_IDLE;
            end
            FETCH_RUN:
                if (load) begin
                    state_nxt    = FETCH_LOAD;
                    wp_nxt       = '0;
                    count_nxt    = '0;
                    op_valid_nxt = 1'b0;
                end else if (!run) begin
                    state_nxt    = FETCH_IDLE;
                    op_valid_nxt = 1'b0;
                end else if (move_next && op_valid) begin
                    if (!last) begin
                        pc_nxt = pc + AW'(1);
                        op_nxt = rdata;
                    end else begin
`ifdef NIBBLE_FETCH_LOOP_EN
                        pc_nxt = '0;
                        raddr  = '0;
                        op_nxt = rdata;
`else
                        state_nxt    = FETCH_HALT;
                        op_valid_nxt = 1'b0;
                        halted_nxt   = 1'b1;
`endif
                    end
                end
            FETCH_HALT:
                if (load) begin
                    state_nxt  = FETCH_LOAD;
                    wp_nxt     = '0;
                    count_nxt  = '0;
                    halted_nxt = 1'b0;
                end else if (!run) begin
                    state_nxt  = FETCH_IDLE;
                    halted_nxt = 1'b0;
                end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            wp       <= '0;
            count    <= '0;
            full     <= 1'b0;
            pc       <= '0;
            op       <= '0;
            op_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wp       <= wp_nxt;
            count    <= count_nxt;
            full     <= count_nxt == (AW+1)'(DEPTH);
            pc       <= pc_nxt;
            op       <= op_nxt;
            op_valid <= op_valid_nxt;
            halted   <= halted_nxt;
        end
    end

endmodule
